// File: rtl/ps_pwm_nch.sv
// N-channel phase-shifted PWM modulator: per-channel sawtooth carriers staggered by
// (period+1)/N_CH, glitch-free shadowed duties and complementary outputs with dead time.
module ps_pwm_nch #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DT_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_W-1:0]        period,
  input  logic                    duty_wr,
  input  logic [$clog2(N_CH)-1:0] duty_ch,
  input  logic [CNT_W-1:0]        duty_data,
  input  logic [DT_W-1:0]         dead_time,
  output logic [N_CH-1:0]         pwm_h,
  output logic [N_CH-1:0]         pwm_l,
  output logic                    sync,
  output logic                    running
);

  localparam int unsigned ChW = $clog2(N_CH);
  localparam int unsigned CW1 = CNT_W + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               per_q, per_d;
  logic [N_CH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_CH-1:0][CNT_W-1:0]     shadow_q, shadow_d;
  logic [N_CH-1:0][CNT_W-1:0]     act_q, act_d;
  logic [N_CH-1:0][DT_W-1:0]      dt_q, dt_d;
  logic [N_CH-1:0]                raw_q, raw_d;
  logic [N_CH-1:0]                pwm_h_q, pwm_h_d;
  logic [N_CH-1:0]                pwm_l_q, pwm_l_d;
  logic                           sync_q, sync_d;

  logic [CW1-1:0]                 per_p1;
  logic [CW1-1:0]                 step;
  logic [CW1-1:0]                 offs;
  logic [N_CH-1:0][CNT_W-1:0]     cnt_load;
  logic [N_CH-1:0]                raw;

  // Start-up carrier values: channel k sits k*step counts behind channel 0.
  always_comb begin
    per_p1   = CW1'(period) + CW1'(1);
    step     = per_p1 >> ChW;
    offs     = '0;
    cnt_load = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      offs = CW1'(k) * step;
      // A zero offset must map to 0, not to per+1 truncated.
      cnt_load[k] = (offs == '0) ? '0 : CNT_W'(per_p1 - offs);
    end
  end

  always_comb begin
    raw = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      raw[k] = {1'b0, cnt_q[k]} < {1'b0, act_q[k]};
    end
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    shadow_d = shadow_q;
    dt_d     = '0;
    raw_d    = '0;
    pwm_h_d  = '0;
    pwm_l_d  = '0;
    sync_d   = 1'b0;

    if (duty_wr) begin
      shadow_d[duty_ch] = duty_data;
    end

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StRun;
          per_d   = period;
          cnt_d   = cnt_load;
          act_d   = shadow_q;
        end
      end
      StRun: begin
        if (!en) begin
          state_d = StIdle;
        end else begin
          sync_d = (cnt_q[0] == '0);
          for (int unsigned k = 0; k < N_CH; k++) begin
            // Shadow is sampled before this clock's write lands.
            if (cnt_q[k] == per_q) begin
              cnt_d[k] = '0;
              act_d[k] = shadow_q[k];
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end

            raw_d[k] = raw[k];
            if (raw[k] != raw_q[k]) begin
              dt_d[k] = dead_time;
            end else if (dt_q[k] != '0) begin
              dt_d[k] = dt_q[k] - 1'b1;
            end

            pwm_h_d[k] = (dt_d[k] == '0) && raw[k];
            pwm_l_d[k] = (dt_d[k] == '0) && !raw[k];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      per_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      act_q    <= '0;
      dt_q     <= '0;
      raw_q    <= '0;
      pwm_h_q  <= '0;
      pwm_l_q  <= '0;
      sync_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      act_q    <= act_d;
      dt_q     <= dt_d;
      raw_q    <= raw_d;
      pwm_h_q  <= pwm_h_d;
      pwm_l_q  <= pwm_l_d;
      sync_q   <= sync_d;
    end
  end

  assign pwm_h   = pwm_h_q;
  assign pwm_l   = pwm_l_q;
  assign sync    = sync_q;
  assign running = (state_q == StRun);

endmodule

// File: tb/tb_ps_pwm_nch.sv
// Bench for ps_pwm_nch: directed scenarios plus random traffic, every cycle compared
// against a time-based reference model (carrier phase from elapsed clocks).
module tb_ps_pwm_nch;

  localparam int NCh     = 4;
  localparam int CntW    = 8;
  localparam int DtW     = 4;
  localparam int ChW     = $clog2(NCh);
  localparam int Settled = 1000;
  localparam int HistN   = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic [CntW-1:0] period = '0;
  logic            duty_wr = 1'b0;
  logic [ChW-1:0]  duty_ch = '0;
  logic [CntW-1:0] duty_data = '0;
  logic [DtW-1:0]  dead_time = '0;
  logic [NCh-1:0]  pwm_h, pwm_l;
  logic            sync, running;

  always #5 clk = ~clk;

  ps_pwm_nch #(
    .N_CH (NCh),
    .CNT_W(CntW),
    .DT_W (DtW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .period   (period),
    .duty_wr  (duty_wr),
    .duty_ch  (duty_ch),
    .duty_data(duty_data),
    .dead_time(dead_time),
    .pwm_h    (pwm_h),
    .pwm_l    (pwm_l),
    .sync     (sync),
    .running  (running)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: carrier of channel k after n run clocks is (n - k*step) mod (per+1);
  // an output side is allowed on once its raw level has been stable for dead_time clocks.
  bit             m_run;
  int             m_n, m_per;
  int             m_shadow[NCh], m_act[NCh], m_age[NCh];
  bit             m_rawprev[NCh];
  logic [NCh-1:0] e_h, e_l;
  logic           e_sync, e_running;

  logic [NCh-1:0] hh[HistN];
  logic           ss[HistN];

  function automatic int carrier(input int k);
    int p1, step;
    p1   = m_per + 1;
    step = p1 / NCh;
    return (((m_n - k * step) % p1) + p1) % p1;
  endfunction

  task automatic model_edge();
    int c;
    bit r;
    if (rst) begin
      m_run = 0; m_n = 0; m_per = 0;
      for (int k = 0; k < NCh; k++) begin
        m_shadow[k] = 0; m_act[k] = 0; m_rawprev[k] = 0; m_age[k] = Settled;
      end
      e_h = '0; e_l = '0; e_sync = 1'b0; e_running = 1'b0;
      return;
    end
    e_h = '0; e_l = '0; e_sync = 1'b0;
    if (m_run && en) begin
      for (int k = 0; k < NCh; k++) begin
        c = carrier(k);
        r = (c < m_act[k]);
        if (k == 0) e_sync = (c == 0);
        if (r != m_rawprev[k]) m_age[k] = 0;
        else if (m_age[k] < Settled) m_age[k]++;
        m_rawprev[k] = r;
        if (m_age[k] >= int'(dead_time)) begin
          e_h[k] = r;
          e_l[k] = !r;
        end
        if (c == m_per) m_act[k] = m_shadow[k];
      end
      m_n++;
    end else if (m_run) begin
      m_run = 0;
      for (int k = 0; k < NCh; k++) begin
        m_rawprev[k] = 0; m_age[k] = Settled;
      end
    end else if (en) begin
      m_run = 1; m_per = int'(period); m_n = 0;
      for (int k = 0; k < NCh; k++) m_act[k] = m_shadow[k];
    end
    if (duty_wr) m_shadow[duty_ch] = int'(duty_data);
    e_running = m_run;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pwm_h", 32'(pwm_h), 32'(e_h));
    chk("pwm_l", 32'(pwm_l), 32'(e_l));
    chk("sync", 32'(sync), 32'(e_sync));
    chk("running", 32'(running), 32'(e_running));
    chk("no_overlap", 32'(pwm_h & pwm_l), 32'd0);
  endtask

  task automatic set_duty(input int ch, input int val);
    duty_wr   = 1'b1;
    duty_ch   = ChW'(ch);
    duty_data = CntW'(val);
    tick();
    duty_wr   = 1'b0;
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      hh[i] = pwm_h;
      ss[i] = sync;
    end
  endtask

  function automatic int first_rise(input int ch, input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      if (hh[i][ch] && !hh[i-1][ch]) return i;
    end
    return -1000;
  endfunction

  function automatic int sync_gap(input int upto);
    int a;
    a = -1;
    for (int i = 0; i < upto; i++) begin
      if (ss[i]) begin
        if (a < 0) a = i;
        else return i - a;
      end
    end
    return -1;
  endfunction

  initial begin
    int cnt, lcnt, both, r0, tog;
    int hi[NCh];
    logic [NCh-1:0] prev;

    // Reset held with en high
    en = 1'b1; period = 8'd15;
    tick(); tick();
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_pwm_h", 32'(pwm_h), 32'd0);
    chk("rst_pwm_l", 32'(pwm_l), 32'd0);
    rst = 1'b0;
    tick();
    chk("running_after_release", 32'(running), 32'd1);
    tick();
    chk("first_sync", 32'(sync), 32'd1);

    // Phase shift, period 15, duty 8
    en = 1'b0; tick();
    for (int k = 0; k < NCh; k++) set_duty(k, 8);
    period = 8'd15; dead_time = '0; en = 1'b1;
    tick();
    record(HistN);
    cnt = 0;
    for (int i = 16; i < 32; i++) cnt += int'(hh[i][0]);
    chk("ch0_high_8_of_16", cnt, 8);
    r0 = first_rise(0, 16, HistN);
    for (int k = 1; k < NCh; k++) begin
      chk($sformatf("lag_ch%0d", k), first_rise(k, r0, HistN) - r0, 4 * k);
    end
    chk("sync_interval_16", sync_gap(HistN), 16);

    // Duty extremes
    set_duty(0, 0); set_duty(1, 16); set_duty(2, 255);
    repeat (20) tick();
    for (int k = 0; k < NCh; k++) hi[k] = 0;
    tog = 0; prev = pwm_h;
    for (int i = 0; i < 32; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        hi[k] += int'(pwm_h[k]);
        if (pwm_h[k] != prev[k]) tog++;
      end
      prev = pwm_h;
    end
    chk("duty0_never_high", hi[0], 0);
    chk("duty16_always_high", hi[1], 32);
    chk("duty255_always_high", hi[2], 32);
    chk("extremes_no_toggle", tog, 0);

    // Shadow timing on channel 0
    set_duty(0, 8);
    repeat (20) tick();
    for (int i = 0; i < 32 && carrier(0) != 5; i++) tick();
    set_duty(0, 4);
    tick();
    chk("old_duty_holds", 32'(pwm_h[0]), 32'd1);
    for (int i = 0; i < 32 && carrier(0) != 15; i++) tick();
    set_duty(0, 12);
    cnt = 0;
    repeat (16) begin tick(); cnt += int'(pwm_h[0]); end
    chk("duty4_after_wrap", cnt, 4);
    cnt = 0;
    repeat (16) begin tick(); cnt += int'(pwm_h[0]); end
    chk("wrap_write_next_period", cnt, 12);

    // Dead time 3
    en = 1'b0; tick();
    dead_time = 4'd3;
    set_duty(0, 8);
    en = 1'b1;
    repeat (40) tick();
    cnt = 0; lcnt = 0; both = 0;
    repeat (16) begin
      tick();
      cnt  += int'(pwm_h[0]);
      lcnt += int'(pwm_l[0]);
      both += int'(!pwm_h[0] && !pwm_l[0]);
    end
    chk("dt_high_5", cnt, 5);
    chk("dt_low_5", lcnt, 5);
    chk("dt_both_off_6", both, 6);

    // Disable mid-period, re-enable with period 7
    for (int i = 0; i < 32 && carrier(0) != 6; i++) tick();
    en = 1'b0;
    tick();
    chk("off_pwm_h", 32'(pwm_h), 32'd0);
    chk("off_pwm_l", 32'(pwm_l), 32'd0);
    chk("off_sync", 32'(sync), 32'd0);
    dead_time = '0;
    for (int k = 0; k < NCh; k++) set_duty(k, 4);
    period = 8'd7; en = 1'b1;
    tick();
    record(32);
    chk("sync_interval_8", sync_gap(32), 8);
    r0 = first_rise(0, 8, 32);
    chk("lag_ch1_step2", first_rise(1, r0, 32) - r0, 2);
    cnt = 0;
    for (int i = 8; i < 16; i++) cnt += int'(hh[i][0]);
    chk("ch0_high_4_of_8", cnt, 4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      duty_wr   = ($urandom_range(2) == 0);
      duty_ch   = ChW'($urandom_range(NCh - 1));
      duty_data = ($urandom_range(7) == 0) ? CntW'($urandom_range(255))
                                           : CntW'($urandom_range(int'(period) + 2));
      if ($urandom_range(9) == 0) period = CntW'($urandom_range(255));
      if ($urandom_range(39) == 0) begin
        en = 1'b0;
        tick();
        case ($urandom_range(5))
          0:       period = 8'd0;
          1:       period = 8'd1;
          2:       period = 8'd3;
          3:       period = 8'd7;
          4:       period = 8'd15;
          default: period = CntW'($urandom_range(40));
        endcase
        dead_time = DtW'($urandom_range(5));
        en = 1'b1;
      end
      if (i == 300) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    duty_wr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
